// File: rtl/memory_arbiter_rr.sv
// Round-robin arbiter sharing one RAM port between CPUS cores, each with an
// instruction-read and a data read/write channel; one transaction in flight at a time.
module memory_arbiter_rr #(
    parameter int CPUS   = 2,
    parameter int WORD_W = 32
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [CPUS-1:0]              iREN,
    input  logic [CPUS-1:0]              dREN,
    input  logic [CPUS-1:0]              dWEN,
    input  logic [CPUS-1:0][WORD_W-1:0]  iaddr,
    input  logic [CPUS-1:0][WORD_W-1:0]  daddr,
    input  logic [CPUS-1:0][WORD_W-1:0]  dstore,
    output logic [CPUS-1:0]              iwait,
    output logic [CPUS-1:0]              dwait,
    output logic [CPUS-1:0][WORD_W-1:0]  iload,
    output logic [CPUS-1:0][WORD_W-1:0]  dload,
    output logic [WORD_W-1:0]            ramaddr,
    output logic [WORD_W-1:0]            ramstore,
    output logic                         ramREN,
    output logic                         ramWEN,
    input  logic [1:0]                   ramstate,
    input  logic [WORD_W-1:0]            ramload
);

    localparam int PW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    state_t                      state, state_nxt;
    logic [PW-1:0]               rr_ptr;
    logic [PW-1:0]               gnt_core;
    logic                        gnt_d;
    logic                        gnt_wen;
    logic [WORD_W-1:0]           gnt_addr;
    logic [WORD_W-1:0]           gnt_store;
    logic [CPUS-1:0][WORD_W-1:0] iload_r;
    logic [CPUS-1:0][WORD_W-1:0] dload_r;

    logic [CPUS-1:0] d_req;
    logic [PW:0]     scan_sum;
    logic [PW-1:0]   scan_idx;
    logic [PW-1:0]   sel_core;
    logic            sel_d;
    logic            sel_any;
    logic            done;
    logic            gnt_live;
    logic            rd_done;
    logic [PW-1:0]   ptr_nxt;

    assign d_req = dREN | dWEN;

    // Scan cores starting at rr_ptr, wrapping; the data channel beats the instruction channel.
    always_comb begin
        sel_any  = 1'b0;
        sel_core = '0;
        sel_d    = 1'b0;
        scan_sum = '0;
        scan_idx = '0;
        for (int i = 0; i < CPUS; i++) begin
            scan_sum = {1'b0, rr_ptr} + (PW+1)'(i);
            if (scan_sum >= (PW+1)'(CPUS))
                scan_sum = scan_sum - (PW+1)'(CPUS);
            scan_idx = scan_sum[PW-1:0];
            if (!sel_any && (d_req[scan_idx] || iREN[scan_idx])) begin
                sel_any  = 1'b1;
                sel_core = scan_idx;
                sel_d    = d_req[scan_idx];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sel_any) state_nxt = ISSUE;
            ISSUE:   if (ramstate == RS_ACCESS || ramstate == RS_ERROR) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign done     = (state == ISSUE) && (ramstate == RS_ACCESS);
    assign gnt_live = gnt_d ? d_req[gnt_core] : iREN[gnt_core];
    // A requester that withdrew mid-transaction gets no load update.
    assign rd_done  = done && !gnt_wen && gnt_live;
    assign ptr_nxt  = (gnt_core == PW'(CPUS - 1)) ? '0 : gnt_core + PW'(1);

    assign ramREN   = (state == ISSUE) && !gnt_wen;
    assign ramWEN   = (state == ISSUE) && gnt_wen;
    assign ramaddr  = (state == ISSUE) ? gnt_addr  : '0;
    assign ramstore = (state == ISSUE) ? gnt_store : '0;

    always_comb begin
        dwait = d_req;
        iwait = iREN;
        dload = dload_r;
        iload = iload_r;
        if (done) begin
            if (gnt_d) begin
                dwait[gnt_core] = 1'b0;
                if (rd_done) dload[gnt_core] = ramload;
            end else begin
                iwait[gnt_core] = 1'b0;
                if (rd_done) iload[gnt_core] = ramload;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            gnt_core  <= '0;
            gnt_d     <= 1'b0;
            gnt_wen   <= 1'b0;
            gnt_addr  <= '0;
            gnt_store <= '0;
            iload_r   <= '0;
            dload_r   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && sel_any) begin
                gnt_core  <= sel_core;
                gnt_d     <= sel_d;
                gnt_wen   <= sel_d && dWEN[sel_core];
                gnt_addr  <= sel_d ? daddr[sel_core] : iaddr[sel_core];
                gnt_store <= sel_d ? dstore[sel_core] : '0;
            end
            // An ERROR leaves rr_ptr alone so the failed requester is retried first.
            if (done)
                rr_ptr <= ptr_nxt;
            if (rd_done) begin
                if (gnt_d) dload_r[gnt_core] <= ramload;
                else       iload_r[gnt_core] <= ramload;
            end
        end
    end

endmodule

// File: tb/tb_memory_arbiter_rr.sv
// Scoreboard bench for memory_arbiter_rr (CPUS=2): a RAM responder answers each
// transaction, expected grants are queued at stimulus time and popped on completion.
module tb_memory_arbiter_rr;

    logic             CLK = 1'b0;
    logic             RST;
    logic [1:0]       iREN, dREN, dWEN;
    logic [1:0][31:0] iaddr, daddr, dstore;
    logic [1:0]       iwait, dwait;
    logic [1:0][31:0] iload, dload;
    logic [31:0]      ramaddr, ramstore, ramload;
    logic             ramREN, ramWEN;
    logic [1:0]       ramstate;

    memory_arbiter_rr #(.CPUS(2), .WORD_W(32)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN),
        .ramstate(ramstate), .ramload(ramload)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          c;
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] store;
        logic [31:0] ld;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] mdl_d [2];
    logic [31:0] mdl_i [2];
    int          busy_n = 0;
    bit          err_pend = 1'b0;
    int          cnt = 0;
    bit          trk = 1'b0;
    int          run0 = 0, run1 = 0, max_run = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
    endfunction

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected load output at completion follows the bench's own load model.
    task automatic push_exp(input bit c, input bit is_d, input bit we, input logic [31:0] addr,
                            input logic [31:0] store, input bit drop);
        exp_t e;
        e.c = c; e.is_d = is_d; e.we = we; e.addr = addr; e.store = store;
        if (is_d) begin
            if (!we && !drop) mdl_d[c] = mem_rd(addr);
            e.ld = mdl_d[c];
        end else begin
            if (!drop) mdl_i[c] = mem_rd(addr);
            e.ld = mdl_i[c];
        end
        sb.push_back(e);
    endtask

    task automatic wait_cmpl(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge CLK);
            if ((ramREN || ramWEN) && ramstate == 2'd2) got = 1'b1;
        end
        chk_eq(tag, got, 1);
        @(posedge CLK); #1;
    endtask

    task automatic wait_ren(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge CLK);
            if (ramREN) got = 1'b1;
        end
        chk_eq(tag, got, 1);
    endtask

    task automatic wait_err(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge CLK);
            if (ramstate == 2'd3) got = 1'b1;
        end
        chk_eq(tag, got, 1);
    endtask

    // RAM responder: busy_n BUSY cycles, then an optional one-shot ERROR, then ACCESS.
    initial begin
        ramstate = 2'd0;
        ramload  = '0;
        forever begin
            @(posedge CLK); #2;
            if (ramREN || ramWEN) begin
                if (cnt < busy_n) begin
                    ramstate = 2'd1; cnt++;
                end else if (err_pend) begin
                    ramstate = 2'd3; err_pend = 1'b0; cnt = 0;
                end else begin
                    ramstate = 2'd2; cnt = 0;
                end
            end else begin
                ramstate = 2'd0; cnt = 0;
            end
            ramload = mem_rd(ramaddr);
        end
    end

    // Completion monitor and stall-length tracker.
    initial begin
        forever begin
            @(negedge CLK);
            if (!RST && (ramREN || ramWEN) && ramstate == 2'd2) begin
                if (sb.size() == 0) begin
                    chk_eq("sb_underflow", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk_eq("sb_addr", ramaddr, e.addr);
                    chk_eq("sb_wen", ramWEN, e.we);
                    chk_eq("sb_ren", ramREN, !e.we);
                    if (e.we) chk_eq("sb_store", ramstore, e.store);
                    if (e.is_d) begin
                        chk_eq("sb_dwait", dwait[e.c], 0);
                        chk_eq("sb_dload", dload[e.c], e.ld);
                    end else begin
                        chk_eq("sb_iwait", iwait[e.c], 0);
                        chk_eq("sb_iload", iload[e.c], e.ld);
                    end
                end
            end
            if (trk) begin
                run0 = iwait[0] ? run0 + 1 : 0;
                run1 = iwait[1] ? run1 + 1 : 0;
                if (run0 > max_run) max_run = run0;
                if (run1 > max_run) max_run = run1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RST = 1'b1; iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        for (int k = 0; k < 2; k++) begin mdl_d[k] = '0; mdl_i[k] = '0; end

        // reset: stalls mirror requests, RAM port idle, loads cleared
        #12; dREN = 2'b01; iREN = 2'b10; #1;
        chk_eq("rst_dwait", dwait, 2'b01);
        chk_eq("rst_iwait", iwait, 2'b10);
        chk_eq("rst_ram_en", {ramREN, ramWEN}, 0);
        chk_eq("rst_ramaddr", ramaddr, 0);
        chk_eq("rst_dload", dload, 0);
        chk_eq("rst_iload", iload, 0);
        dREN = '0; iREN = '0;
        @(negedge CLK); RST = 1'b0;

        // single data read, two-cycle latency
        @(posedge CLK); #1;
        daddr[0] = 32'h100; dREN = 2'b01;
        push_exp(1'b0, 1'b1, 1'b0, 32'h100, 0, 1'b0);
        @(negedge CLK);
        chk_eq("a_c0_ren", ramREN, 0);
        chk_eq("a_c0_dwait", dwait[0], 1);
        @(negedge CLK);
        chk_eq("a_c1_ren", ramREN, 1);
        @(posedge CLK); #1; dREN = '0;
        @(negedge CLK);
        chk_eq("a_dload_hold", dload[0], 32'hDEADBEEF);

        // write beats instruction read on the same core, one IDLE cycle between grants
        @(posedge CLK); #1;
        daddr[0] = 32'h200; dstore[0] = 32'h55; iaddr[0] = 32'h300;
        dWEN = 2'b01; iREN = 2'b01;
        push_exp(1'b0, 1'b1, 1'b1, 32'h200, 32'h55, 1'b0);
        push_exp(1'b0, 1'b0, 1'b0, 32'h300, 0, 1'b0);
        wait_cmpl("b_wr_cmpl"); dWEN = '0;
        @(negedge CLK);
        chk_eq("b_gap", {ramREN, ramWEN}, 0);
        @(negedge CLK);
        chk_eq("b_regrant", ramREN, 1);
        @(posedge CLK); #1; iREN = '0;

        // both cores fetching continuously: grants alternate (rr_ptr is 1 here)
        @(posedge CLK); #1;
        iaddr[0] = 32'h400; iaddr[1] = 32'h500;
        max_run = 0; run0 = 0; run1 = 0; trk = 1'b1; iREN = 2'b11;
        for (int g = 0; g < 4; g++)
            push_exp(bit'((g + 1) % 2), 1'b0, 1'b0, ((g % 2) == 0) ? 32'h500 : 32'h400, 0, 1'b0);
        for (int g = 0; g < 4; g++) wait_cmpl("c_cmpl");
        iREN = '0; trk = 1'b0;
        chk_eq("c_iwait_run_le4", (max_run <= 4), 1);

        // BUSY x3 then ERROR on core1: retried first, rr_ptr untouched
        @(posedge CLK); #1;
        busy_n = 3; err_pend = 1'b1; daddr[1] = 32'h600; dREN = 2'b10;
        wait_err("d_err_seen");
        chk_eq("d_err_dwait", dwait[1], 1);
        @(posedge CLK); #1;
        busy_n = 0; daddr[0] = 32'h700; dREN = 2'b11;
        push_exp(1'b1, 1'b1, 1'b0, 32'h600, 0, 1'b0);
        push_exp(1'b0, 1'b1, 1'b0, 32'h700, 0, 1'b0);
        @(negedge CLK);
        chk_eq("d_idle_ren", ramREN, 0);
        chk_eq("d_idle_dwait", dwait[1], 1);
        wait_cmpl("d_retry_cmpl"); dREN = 2'b01;
        wait_cmpl("d_core0_cmpl"); dREN = '0;

        // core1 withdraws mid-ISSUE: access completes, dload[1] untouched, core0 next
        @(posedge CLK); #1;
        busy_n = 2; daddr[1] = 32'h800; daddr[0] = 32'h900; dREN = 2'b11;
        push_exp(1'b1, 1'b1, 1'b0, 32'h800, 0, 1'b1);
        push_exp(1'b0, 1'b1, 1'b0, 32'h900, 0, 1'b0);
        wait_ren("f_issue");
        @(posedge CLK); #1; dREN = 2'b01;
        wait_cmpl("f_drop_cmpl");
        wait_cmpl("f_core0_cmpl"); dREN = '0;
        @(negedge CLK);
        chk_eq("f_dload1_hold", dload[1], mdl_d[1]);

        // reset mid-ISSUE while RAM is BUSY
        @(posedge CLK); #1;
        busy_n = 5; daddr[0] = 32'hA00; dREN = 2'b01;
        wait_ren("e_issue");
        #1; RST = 1'b1; #1;
        chk_eq("e_rst_ren", ramREN, 0);
        chk_eq("e_rst_ramaddr", ramaddr, 0);
        chk_eq("e_rst_dload", dload, 0);
        chk_eq("e_rst_iload", iload, 0);
        for (int k = 0; k < 2; k++) begin mdl_d[k] = '0; mdl_i[k] = '0; end
        busy_n = 0; daddr[1] = 32'hB00; dREN = 2'b11; #1;
        chk_eq("e_rst_dwait", dwait, 2'b11);
        @(posedge CLK); @(negedge CLK); RST = 1'b0;
        push_exp(1'b0, 1'b1, 1'b0, 32'hA00, 0, 1'b0);
        push_exp(1'b1, 1'b1, 1'b0, 32'hB00, 0, 1'b0);
        wait_cmpl("e_core0_cmpl"); dREN = 2'b10;
        wait_cmpl("e_core1_cmpl"); dREN = '0;

        repeat (2) @(negedge CLK);
        chk_eq("end_dload0", dload[0], mdl_d[0]);
        chk_eq("end_dload1", dload[1], mdl_d[1]);
        chk_eq("end_iload0", iload[0], mdl_i[0]);
        chk_eq("end_iload1", iload[1], mdl_i[1]);
        chk_eq("end_sb_left", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
